// File: rtl/zx_keyboard.sv
// zx_keyboard -- PS/2 set-2 keyboard to ZX Spectrum 8x5 key matrix.
//
// Receives PS/2 frames (device-to-host only) and keeps the Spectrum key matrix.
// It answers the input side of port 0xFE: the column bits for the rows
// selected (active low) by A[15:8].
//
// Ports:
//   clock       system clock (25 MHz, shared with CPU/ULA)
//   reset_n     asynchronous reset, active low
//   ps2_clk     PS/2 clock line (asynchronous)
//   ps2_dat     PS/2 data line (asynchronous)
//   addr_hi     Z80 A[15:8]; bit r low selects matrix row r
//   keys        active-low column bits D[4:0] for the IN result
//   scan_valid  one-cycle strobe for each good frame
//   scan_code   last good byte, held until the next good frame
//
// Optional build macro: ZX_CURSOR_KEYS_EN. When it is defined, the cursor keys
// (E0 6B/72/75/74) and backspace (66) act as CAPS+5/6/7/8/0.
module zx_keyboard #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 2500
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] addr_hi,
  output logic [4:0] keys,
  output logic       scan_valid,
  output logic [7:0] scan_code
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Location of one key in the matrix.
  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_t;

  // ---------------- synchronizers + clock filter ----------------
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          s_clk, s_dat;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          flt_q, flt_d, fall;

  assign s_clk = clk_sync_q[1];
  assign s_dat = dat_sync_q[1];

  // The filtered level flips only after FILTER_LEN consecutive samples that
  // differ from it. fall marks the cycle in which it drops from 1 to 0.
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    fall      = 1'b0;
    if (s_clk != flt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        flt_d = s_clk;
        fall  = ~s_clk;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      flt_q      <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      flt_q      <= flt_d;
      flt_cnt_q  <= flt_cnt_d;
    end
  end

  // ---------------- frame receiver ----------------
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          good;
  logic          scan_valid_q;
  logic [7:0]    scan_code_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    good      = 1'b0;
    // The timeout counter runs only inside a frame and restarts on every edge.
    if (state_q == S_IDLE || fall) to_cnt_d = '0;
    else                           to_cnt_d = to_cnt_q + 1'b1;

    case (state_q)
      S_IDLE:   if (fall && !s_dat) begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
                end
      S_DATA:   if (fall) begin
                  shift_d   = {s_dat, shift_q[7:1]};  // LSB arrives first
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
      S_PARITY: if (fall) begin
                  par_d   = s_dat;
                  state_d = S_STOP;
                end
      S_STOP:   if (fall) begin
                  // Odd parity over data and parity, plus a high stop bit.
                  good    = s_dat & (^{shift_q, par_q});
                  state_d = S_IDLE;
                end
      default:  state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !fall && to_cnt_q == TW'(TIMEOUT - 1))
      state_d = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      scan_valid_q <= good;
      if (good) scan_code_q <= shift_q;
    end
  end

  assign scan_valid = scan_valid_q;
  assign scan_code  = scan_code_q;

  // ---------------- scancode decoder ----------------
  function automatic key_t map_key(input logic [7:0] c);
    key_t k;
    case (c)
      8'h12: k = {1'b1, 3'd0, 3'd0};  8'h1A: k = {1'b1, 3'd0, 3'd1};
      8'h22: k = {1'b1, 3'd0, 3'd2};  8'h21: k = {1'b1, 3'd0, 3'd3};
      8'h2A: k = {1'b1, 3'd0, 3'd4};
      8'h1C: k = {1'b1, 3'd1, 3'd0};  8'h1B: k = {1'b1, 3'd1, 3'd1};
      8'h23: k = {1'b1, 3'd1, 3'd2};  8'h2B: k = {1'b1, 3'd1, 3'd3};
      8'h34: k = {1'b1, 3'd1, 3'd4};
      8'h15: k = {1'b1, 3'd2, 3'd0};  8'h1D: k = {1'b1, 3'd2, 3'd1};
      8'h24: k = {1'b1, 3'd2, 3'd2};  8'h2D: k = {1'b1, 3'd2, 3'd3};
      8'h2C: k = {1'b1, 3'd2, 3'd4};
      8'h16: k = {1'b1, 3'd3, 3'd0};  8'h1E: k = {1'b1, 3'd3, 3'd1};
      8'h26: k = {1'b1, 3'd3, 3'd2};  8'h25: k = {1'b1, 3'd3, 3'd3};
      8'h2E: k = {1'b1, 3'd3, 3'd4};
      8'h45: k = {1'b1, 3'd4, 3'd0};  8'h46: k = {1'b1, 3'd4, 3'd1};
      8'h3E: k = {1'b1, 3'd4, 3'd2};  8'h3D: k = {1'b1, 3'd4, 3'd3};
      8'h36: k = {1'b1, 3'd4, 3'd4};
      8'h4D: k = {1'b1, 3'd5, 3'd0};  8'h44: k = {1'b1, 3'd5, 3'd1};
      8'h43: k = {1'b1, 3'd5, 3'd2};  8'h3C: k = {1'b1, 3'd5, 3'd3};
      8'h35: k = {1'b1, 3'd5, 3'd4};
      8'h5A: k = {1'b1, 3'd6, 3'd0};  8'h4B: k = {1'b1, 3'd6, 3'd1};
      8'h42: k = {1'b1, 3'd6, 3'd2};  8'h3B: k = {1'b1, 3'd6, 3'd3};
      8'h33: k = {1'b1, 3'd6, 3'd4};
      8'h29: k = {1'b1, 3'd7, 3'd0};  8'h59: k = {1'b1, 3'd7, 3'd1};
      8'h3A: k = {1'b1, 3'd7, 3'd2};  8'h31: k = {1'b1, 3'd7, 3'd3};
      8'h32: k = {1'b1, 3'd7, 3'd4};
      default: k = '0;
    endcase
    return k;
  endfunction

  logic [7:0][4:0] matrix_q, matrix_d;  // 0 = pressed
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [4:0]      virt_q, virt_d;      // 1 = held: left, down, up, right, bksp
  logic [7:0][4:0] eff;
  key_t            kinfo;

  assign kinfo = map_key(scan_code_q);

  // Works off the registered strobe, so a read in the same cycle still sees
  // the previous matrix.
  always_comb begin
    matrix_d = matrix_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    virt_d   = virt_q;
    if (scan_valid_q) begin
      if (scan_code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (scan_code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (scan_code_q == 8'h00 || scan_code_q == 8'hFF) begin
          matrix_d = '1;
          virt_d   = '0;
        end else if (!ext_q && kinfo.hit) begin
          matrix_d[kinfo.row][kinfo.col] = brk_q;
        end
`ifdef ZX_CURSOR_KEYS_EN
        case ({ext_q, scan_code_q})
          9'h16B:  virt_d[0] = ~brk_q;
          9'h172:  virt_d[1] = ~brk_q;
          9'h175:  virt_d[2] = ~brk_q;
          9'h174:  virt_d[3] = ~brk_q;
          9'h066:  virt_d[4] = ~brk_q;
          default: ;
        endcase
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      matrix_q <= '1;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      virt_q   <= '0;
    end else begin
      matrix_q <= matrix_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      virt_q   <= virt_d;
    end
  end

  // Virtual keys overlay the physical matrix; each has its own held bit, so
  // releasing one never releases a physically held key.
  always_comb begin
    eff = matrix_q;
`ifdef ZX_CURSOR_KEYS_EN
    eff[3][4] = matrix_q[3][4] & ~virt_q[0];
    eff[4][4] = matrix_q[4][4] & ~virt_q[1];
    eff[4][3] = matrix_q[4][3] & ~virt_q[2];
    eff[4][2] = matrix_q[4][2] & ~virt_q[3];
    eff[4][0] = matrix_q[4][0] & ~virt_q[4];
    eff[0][0] = matrix_q[0][0] & ~(|virt_q);
`endif
  end

  // ---------------- read path ----------------
  always_comb begin
    keys = 5'h1F;
    for (int r = 0; r < 8; r++)
      if (!addr_hi[r]) keys = keys & eff[r];
  end

endmodule

// File: tb/tb_zx_keyboard.sv
module tb_zx_keyboard;
  localparam int TMO = 2500;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] addr_hi = 8'h00;
  logic [4:0] keys;
  logic       scan_valid;
  logic [7:0] scan_code;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int wide_cnt = 0;
  logic [7:0] last_code = 8'h00;
  logic prev_v = 1'b0;

  zx_keyboard dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .addr_hi(addr_hi), .keys(keys), .scan_valid(scan_valid), .scan_code(scan_code)
  );

  always #20 clock = ~clock;

  // Strobe monitor: counts strobes and any strobe lasting more than one cycle.
  always @(negedge clock) begin
    if (scan_valid) begin
      if (prev_v) wide_cnt++;
      else        strobe_cnt++;
      last_code = scan_code;
    end
    prev_v = scan_valid;
  end

  task automatic ps2_bit(input logic b);
    @(negedge clock) ps2_dat = b;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] c, input logic bad_par = 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(~^c ^ bad_par);
    ps2_bit(1'b1);
    repeat (20) @(negedge clock);
  endtask

  task automatic rd(input logic [7:0] a);
    @(negedge clock) addr_hi = a;
    #1;
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clock);
    #1;
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL reset_keys: got %h exp 1f", keys); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", scan_valid); end
    checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h exp 00", scan_code); end
    @(negedge clock) reset_n = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_press;
    int s0;
    s0 = strobe_cnt;
    send(8'h1C);
    checks++; if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL press_strobe: got %0d exp %0d", strobe_cnt - s0, 1); end
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL press_width: wide strobes %0d exp 0", wide_cnt); end
    checks++; if (last_code !== 8'h1C) begin errors++; $display("FAIL press_code: got %h exp 1c", last_code); end
    checks++; if (scan_code !== 8'h1C) begin errors++; $display("FAIL press_code_held: got %h exp 1c", scan_code); end
    rd(8'hFD);
    checks++; if (keys !== 5'h1E) begin errors++; $display("FAIL press_fd: got %h exp 1e", keys); end
    rd(8'hFF);
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL press_ff: got %h exp 1f", keys); end
  endtask

  task automatic test_release;
    int s0;
    s0 = strobe_cnt;
    send(8'hF0);
    rd(8'hFD);
    checks++; if (keys !== 5'h1E) begin errors++; $display("FAIL release_prefix: got %h exp 1e", keys); end
    checks++; if (last_code !== 8'hF0) begin errors++; $display("FAIL release_f0_code: got %h exp f0", last_code); end
    send(8'h1C);
    rd(8'hFD);
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL release_fd: got %h exp 1f", keys); end
    checks++; if (strobe_cnt !== s0 + 2) begin errors++; $display("FAIL release_strobes: got %0d exp 2", strobe_cnt - s0); end
  endtask

  task automatic test_multi;
    send(8'h12);
    send(8'h1A);
    rd(8'hFE);
    checks++; if (keys !== 5'h1C) begin errors++; $display("FAIL multi_fe: got %h exp 1c", keys); end
    send(8'h29);
    rd(8'h7F);
    checks++; if (keys !== 5'h1E) begin errors++; $display("FAIL multi_7f: got %h exp 1e", keys); end
    rd(8'h7E);
    checks++; if (keys !== 5'h1C) begin errors++; $display("FAIL multi_7e: got %h exp 1c", keys); end
    send(8'hF0); send(8'h12);
    send(8'hF0); send(8'h1A);
    send(8'hF0); send(8'h29);
    rd(8'h00);
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL multi_released: got %h exp 1f", keys); end
  endtask

  task automatic test_errors;
    int s0;
    s0 = strobe_cnt;
    send(8'h1C, 1'b1);
    // Start bit plus four data bits, then silence past the timeout.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 10) @(negedge clock);
    checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL err_no_strobe: got %0d exp 0", strobe_cnt - s0); end
    rd(8'h00);
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL err_keys: got %h exp 1f", keys); end
    send(8'h2E);
    checks++; if (last_code !== 8'h2E) begin errors++; $display("FAIL err_recover_code: got %h exp 2e", last_code); end
    rd(8'hF7);
    checks++; if (keys !== 5'h0F) begin errors++; $display("FAIL err_recover_f7: got %h exp 0f", keys); end
    send(8'hF0); send(8'h2E);
  endtask

  task automatic test_overflow;
    send(8'h15);
    rd(8'hFB);
    checks++; if (keys !== 5'h1E) begin errors++; $display("FAIL ovf_press: got %h exp 1e", keys); end
    send(8'hFF);
    rd(8'hFB);
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL ovf_release: got %h exp 1f", keys); end
  endtask

  task automatic test_cursor;
`ifdef ZX_CURSOR_KEYS_EN
    send(8'hE0); send(8'h6B);
    send(8'h12);
    rd(8'hF7);
    checks++; if (keys !== 5'h0F) begin errors++; $display("FAIL cur_left_5: got %h exp 0f", keys); end
    send(8'hE0); send(8'hF0); send(8'h6B);
    rd(8'hFE);
    checks++; if (keys !== 5'h1E) begin errors++; $display("FAIL cur_caps_held: got %h exp 1e", keys); end
    rd(8'hF7);
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL cur_5_released: got %h exp 1f", keys); end
    send(8'hF0); send(8'h12);
    rd(8'hFE);
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL cur_caps_released: got %h exp 1f", keys); end
`else
    send(8'hE0); send(8'h6B);
    rd(8'h00);
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL cur_unmapped: got %h exp 1f", keys); end
    checks++; if (last_code !== 8'h6B) begin errors++; $display("FAIL cur_code: got %h exp 6b", last_code); end
`endif
  endtask

  task automatic test_reset_midframe;
    send(8'h1C);
    rd(8'hFD);
    checks++; if (keys !== 5'h1E) begin errors++; $display("FAIL mid_pre: got %h exp 1e", keys); end
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    addr_hi = 8'h00;
    reset_n = 1'b0;
    #1;
    checks++; if (keys !== 5'h1F) begin errors++; $display("FAIL mid_keys: got %h exp 1f", keys); end
    checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL mid_code: got %h exp 00", scan_code); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", scan_valid); end
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    send(8'h1A);
    checks++; if (scan_code !== 8'h1A) begin errors++; $display("FAIL mid_fresh_code: got %h exp 1a", scan_code); end
    rd(8'hFE);
    checks++; if (keys !== 5'h1D) begin errors++; $display("FAIL mid_fresh_fe: got %h exp 1d", keys); end
  endtask

  initial begin
    test_reset;
    test_press;
    test_release;
    test_multi;
    test_errors;
    test_overflow;
    test_cursor;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
